xb_read128_arbiter: RTL and testbench
=====================================

Name: xb_read128_arbiter

Overview:
- Round-robin burst scheduler that shares the single host-bound 128-bit Xillybus read stream (user_r_read_128) among 3 ap_fifo producer channels.
- Each grant emits one 128-bit header word followed by a burst of up to BURST data words from one channel, so the host can demultiplex.
- Sits between the 3 HLS ap_fifo output FIFOs and the Xillybus core read-stream FIFO port.
- Holds a small output FIFO that gives the core standard (non-FWFT) read semantics.

Parameters:
- NCH, 3, number of producer channels (fixed at 3; channel id fits 2 bits).
- BURST, 64, maximum data words per grant (1..65535).
- LW, 16, width of each src_level input.
- OBUF_DEPTH, 4, output FIFO depth in words (power of 2, >=2).

Ports:
- bus_clk  in  1  single clock for all logic.
- trn_reset_n  in  1  synchronous active-low reset.
- src_data  in  384  channel i data at [128*i+127:128*i]; valid while src_empty_n[i]=1 (FWFT).
- src_empty_n  in  3  channel has a word available.
- src_level  in  3*LW  channel fill level, channel i at [LW*i+LW-1:LW*i].
- src_done  in  3  channel produces no more data once drained.
- src_read  out  3  pop strobe; the word is consumed in the same cycle.
- user_r_read_128_rden  in  1  core read strobe.
- user_r_read_128_open  in  1  host file open.
- user_r_read_128_data  out  128  output word, valid the cycle after an accepted rden.
- user_r_read_128_empty  out  1  output FIFO empty.
- user_r_read_128_eof  out  1  end of stream.
- cur_grant  out  2  channel currently granted (3 = none).

Behaviour:
- Reset values:
  - src_read=0, data=0, empty=1, eof=0, cur_grant=3.
  - Output FIFO cleared, state=IDLE, rr pointer=2 (so channel 0 has first priority).
  - All per-channel seq counters=0.
- Channel eligibility: elig[i] = (src_level[i] >= BURST) or (src_done[i] and src_level[i] != 0).
- FSM states IDLE, HDR, BURST:
  - IDLE, open=1, any elig: pick the first eligible channel scanning rr+1, rr+2, rr (mod 3). Latch ch and n = min(src_level[ch], BURST) as 16 bits. Set rr=ch, cur_grant=ch, go to HDR. The decision takes 1 cycle.
  - HDR: when the output FIFO is not full, write header {8'hA5, 6'b0, ch, n[15:0], seq[ch][15:0], 80'h0}. Increment seq[ch] (wraps at 16 bits). Go to BURST with rem=n.
  - BURST: each cycle with FIFO not full and src_empty_n[ch]=1, assert src_read[ch] for 1 cycle, write src word, rem--. The transfer with rem==1 goes to IDLE and sets cur_grant=3. If the source is empty or the FIFO is full, stall with src_read low.
- src_read is never asserted outside BURST or for a non-granted channel. At most one bit is set per cycle.
- Output FIFO "not full" means occupancy < OBUF_DEPTH, evaluated after a same-cycle read. A simultaneous read and write in a full FIFO is allowed.
- Core-side read:
  - empty = (occupancy == 0).
  - rden with empty=0 pops the head into the data register at the next edge.
  - rden with empty=1 is ignored; the data register holds its value.
- Throughput: sustained 1 word/cycle inside a burst when the core reads every cycle. Per-grant overhead is 2 cycles (IDLE decision + header).
- Open deassertion (open=0 sampled):
  - Abort: state=IDLE, cur_grant=3, output FIFO flushed, src_read=0 in that cycle.
  - Words already popped are discarded. seq counters are NOT reset.
  - No grants occur while open=0.
- eof is registered. It is 1 when all of the following hold: all src_done=1, all src_level=0, state=IDLE, FIFO empty, open=1. Otherwise it is 0.
- Simultaneous eligibility is resolved only by the rr order above; a channel is never granted twice in a row while another channel is eligible.
- A level update during BURST does not change the latched n.

Test Plan:
- Reset, then ch0 level=64 with 64 words 0x1..0x40, core rden held high:
  - required: header A5,00,0040,0000 appears first, then 0x1..0x40 in order.
  - required: src_read[0] is high for exactly 64 cycles; cur_grant returns to 3.
- All 3 channels level=128, BURST=64:
  - required: header channel order 0,1,2,0,1,2.
  - required: seq per channel goes 0 then 1; each burst is 64 words.
- ch1 src_done=1, level=5:
  - required: header count=5, then 5 words.
  - required: eof rises after the last word is read, with all levels 0.
- Core rden toggled 1 cycle on / 3 off during a burst:
  - required: output FIFO occupancy never exceeds 4; no word is lost or duplicated.
  - required: src_read stalls while the FIFO is full.
- Drop open mid-burst after 10 words:
  - required: next cycle empty=1 and src_read=0; no grant while open=0.
  - required: after reopen, the next header carries seq=1 for that channel.
- Reset asserted mid-burst:
  - required: next edge gives all outputs at reset values and state IDLE.
  - required: the first post-reset grant goes to channel 0.

Source files
------------

// File: rtl/xb_read128_arbiter.sv
// Round-robin burst scheduler that muxes three FWFT producer channels onto one
// 128-bit read stream, with a header word in front of every burst.
module xb_read128_chan #(
  parameter int LW    = 16,
  parameter int BURST = 64
) (
  input  logic [LW-1:0] level,
  input  logic          done,
  output logic          elig,
  output logic [15:0]   n
);
  logic [31:0] lvl32;
  logic        full_burst;

  assign lvl32      = 32'(level);
  assign full_burst = lvl32 >= 32'(BURST);
  assign elig       = full_burst || (done && lvl32 != 32'd0);
  assign n          = full_burst ? 16'(BURST) : 16'(lvl32);
endmodule

module xb_read128_arbiter #(
  parameter int NCH        = 3,
  parameter int BURST      = 64,
  parameter int LW         = 16,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                 bus_clk,
  input  logic                 trn_reset_n,
  input  logic [128*NCH-1:0]   src_data,
  input  logic [NCH-1:0]       src_empty_n,
  input  logic [LW*NCH-1:0]    src_level,
  input  logic [NCH-1:0]       src_done,
  output logic [NCH-1:0]       src_read,
  input  logic                 user_r_read_128_rden,
  input  logic                 user_r_read_128_open,
  output logic [127:0]         user_r_read_128_data,
  output logic                 user_r_read_128_empty,
  output logic                 user_r_read_128_eof,
  output logic [1:0]           cur_grant
);
  localparam int AW = $clog2(OBUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BURST} state_t;

  state_t       state, nstate;
  logic [1:0]   rr, ch, c1, c2, pick;
  logic [15:0]  n, rem;
  logic [15:0]  seq [NCH];
  logic [NCH-1:0] elig;
  logic [15:0]  n_ch [NCH];
  logic [127:0] src_word [NCH];

  logic [127:0] mem [OBUF_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          rd, wr, can_wr, xfer, open;
  logic [127:0]  wdata;

  assign open = user_r_read_128_open;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      xb_read128_chan #(.LW(LW), .BURST(BURST)) u_chan (
        .level (src_level[LW*gi +: LW]),
        .done  (src_done[gi]),
        .elig  (elig[gi]),
        .n     (n_ch[gi])
      );
      assign src_word[gi] = src_data[128*gi +: 128];
    end
  endgenerate

  // Scan order rr+1, rr+2, rr keeps the last winner at lowest priority.
  assign c1   = (rr == 2'd2) ? 2'd0 : rr + 2'd1;
  assign c2   = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
  assign pick = elig[c1] ? c1 : (elig[c2] ? c2 : rr);

  // Room is judged after any same-cycle pop, so a full FIFO can still stream.
  assign rd     = user_r_read_128_rden && (cnt != '0);
  assign can_wr = (cnt != (AW+1)'(OBUF_DEPTH)) || rd;

  assign user_r_read_128_empty = (cnt == '0);

  always_ff @(posedge bus_clk) begin
    if (!trn_reset_n) state <= S_IDLE;
    else              state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (!open) begin
      nstate = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (|elig) nstate = S_HDR;
        S_HDR:   if (can_wr) nstate = S_BURST;
        S_BURST: if (xfer && rem == 16'd1) nstate = S_IDLE;
        default: nstate = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr       = 1'b0;
    xfer     = 1'b0;
    src_read = '0;
    wdata    = {8'hA5, 6'd0, ch, n, seq[ch], 80'd0};
    if (trn_reset_n && open) begin
      case (state)
        S_HDR: wr = can_wr;
        S_BURST: begin
          if (can_wr && src_empty_n[ch]) begin
            wr           = 1'b1;
            xfer         = 1'b1;
            src_read[ch] = 1'b1;
            wdata        = src_word[ch];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge bus_clk) begin
    if (!trn_reset_n) begin
      rr                   <= 2'd2;
      ch                   <= 2'd0;
      n                    <= '0;
      rem                  <= '0;
      cur_grant            <= 2'd3;
      for (int i = 0; i < NCH; i++) seq[i] <= '0;
      wptr                 <= '0;
      rptr                 <= '0;
      cnt                  <= '0;
      user_r_read_128_data <= '0;
      user_r_read_128_eof  <= 1'b0;
    end else begin
      user_r_read_128_eof <= (&src_done) && (src_level == '0) && (state == S_IDLE)
                             && (cnt == '0) && open;
      if (rd) user_r_read_128_data <= mem[rptr];
      if (!open) begin
        cur_grant <= 2'd3;
        wptr      <= '0;
        rptr      <= '0;
        cnt       <= '0;
      end else begin
        case (state)
          S_IDLE: if (|elig) begin
            ch        <= pick;
            n         <= n_ch[pick];
            rr        <= pick;
            cur_grant <= pick;
          end
          S_HDR: if (can_wr) begin
            seq[ch] <= seq[ch] + 16'd1;
            rem     <= n;
          end
          S_BURST: if (xfer) begin
            rem <= rem - 16'd1;
            if (rem == 16'd1) cur_grant <= 2'd3;
          end
          default: ;
        endcase
        if (wr) wptr <= wptr + AW'(1);
        if (rd) rptr <= rptr + AW'(1);
        cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
      end
    end
  end

  always_ff @(posedge bus_clk) begin
    if (wr) mem[wptr] <= wdata;
  end
endmodule

// File: tb/tb_xb_read128_arbiter.sv
// Scoreboard bench for xb_read128_arbiter: queue-backed FWFT sources, a core
// reader with selectable rden patterns, expected words queued up front.
module tb_xb_read128_arbiter;
  logic         bus_clk = 1'b0;
  logic         trn_reset_n;
  logic [383:0] src_data;
  logic [2:0]   src_empty_n;
  logic [47:0]  src_level;
  logic [2:0]   src_done;
  logic [2:0]   src_read;
  logic         rden, open;
  logic [127:0] data;
  logic         empty, eof;
  logic [1:0]   cur_grant;

  xb_read128_arbiter dut (
    .bus_clk               (bus_clk),
    .trn_reset_n           (trn_reset_n),
    .src_data              (src_data),
    .src_empty_n           (src_empty_n),
    .src_level             (src_level),
    .src_done              (src_done),
    .src_read              (src_read),
    .user_r_read_128_rden  (rden),
    .user_r_read_128_open  (open),
    .user_r_read_128_data  (data),
    .user_r_read_128_empty (empty),
    .user_r_read_128_eof   (eof),
    .cur_grant             (cur_grant)
  );

  always #5 bus_clk = ~bus_clk;

  int errs = 0, checks = 0;
  logic [127:0] sb[$];
  logic [127:0] q0[$], q1[$], q2[$];
  int pops[3];
  int tot_pops, tot_reads, max_occ, viol, rmode, tog;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] hdr(input int c, input int n, input int s);
    return {8'hA5, 6'd0, c[1:0], n[15:0], s[15:0], 80'd0};
  endfunction

  function automatic logic [127:0] word(input int c, input int k);
    return {c[7:0], 104'd0, k[15:0]};
  endfunction

  task automatic drive_src();
    src_empty_n     = {q2.size() != 0, q1.size() != 0, q0.size() != 0};
    src_data[127:0]   = (q0.size() != 0) ? q0[0] : '0;
    src_data[255:128] = (q1.size() != 0) ? q1[0] : '0;
    src_data[383:256] = (q2.size() != 0) ? q2[0] : '0;
    src_level = {16'(q2.size()), 16'(q1.size()), 16'(q0.size())};
  endtask

  task automatic push_src(input int c, input int k0, input int cnt);
    for (int k = k0; k < k0 + cnt; k++) begin
      case (c)
        0: q0.push_back(word(0, k));
        1: q1.push_back(word(1, k));
        default: q2.push_back(word(2, k));
      endcase
    end
  endtask

  task automatic expect_burst(input int c, input int n, input int s, input int k0);
    sb.push_back(hdr(c, n, s));
    for (int k = 0; k < n; k++) sb.push_back(word(c, k0 + k));
  endtask

  task automatic cyc();
    @(posedge bus_clk); #2;
  endtask

  task automatic wait_drain(input string tag, input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin cyc(); n++; end
    chk({tag, "_drain"}, 128'(sb.size()), 128'd0);
  endtask

  task automatic wait_pops(input string tag, input int c, input int target);
    int n = 0;
    while (pops[c] < target && n < 300) begin cyc(); n++; end
    chk(tag, 128'(pops[c]), 128'(target));
  endtask

  task automatic do_reset();
    cyc();
    trn_reset_n = 1'b0;
    rmode = 0; rden = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); sb.delete();
    for (int c = 0; c < 3; c++) pops[c] = 0;
    tot_pops = 0; tot_reads = 0; max_occ = 0; viol = 0;
    src_done = 3'b000; open = 1'b1;
    drive_src();
    repeat (2) cyc();
    trn_reset_n = 1'b1;
  endtask

  // Core reader and source model: sample at negedge, act just after posedge.
  initial begin
    logic acc;
    logic [2:0] sr;
    forever begin
      @(negedge bus_clk);
      acc = rden && !empty;
      sr  = src_read;
      if (sr != 3'b000 && (($countones(sr) != 1) || cur_grant == 2'd3 ||
                           sr != (3'b001 << cur_grant)))
        viol++;
      @(posedge bus_clk); #1;
      if (acc) begin
        tot_reads++;
        if (sb.size() == 0) chk("sb_extra", 128'(sb.size()), 128'd1);
        else                chk("stream", data, sb.pop_front());
      end
      if (sr[0]) begin void'(q0.pop_front()); pops[0]++; tot_pops++; end
      if (sr[1]) begin void'(q1.pop_front()); pops[1]++; tot_pops++; end
      if (sr[2]) begin void'(q2.pop_front()); pops[2]++; tot_pops++; end
      drive_src();
      if (tot_pops > 0 && 1 + tot_pops - tot_reads > max_occ) max_occ = 1 + tot_pops - tot_reads;
      case (rmode)
        1:       rden = 1'b1;
        2:       rden = (tog % 4 == 0);
        default: rden = 1'b0;
      endcase
      tog++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    trn_reset_n = 1'b0; rden = 1'b0; open = 1'b1; src_done = 3'b000;
    rmode = 0; tog = 0; viol = 0; tot_pops = 0; tot_reads = 0; max_occ = 0;
    for (int c = 0; c < 3; c++) pops[c] = 0;
    drive_src();
    cyc();
    chk("rst_data", data, 128'd0);
    chk("rst_empty", 128'(empty), 128'd1);
    chk("rst_eof", 128'(eof), 128'd0);
    chk("rst_grant", 128'(cur_grant), 128'd3);
    chk("rst_read", 128'(src_read), 128'd0);

    // single channel, full burst
    do_reset();
    push_src(0, 1, 64); drive_src();
    expect_burst(0, 64, 0, 1);
    rmode = 1;
    wait_drain("t1", 400);
    repeat (3) cyc();
    chk("t1_pops", 128'(pops[0]), 128'd64);
    chk("t1_grant", 128'(cur_grant), 128'd3);
    chk("t1_viol", 128'(viol), 128'd0);

    // three channels competing, two rounds
    do_reset();
    for (int c = 0; c < 3; c++) push_src(c, 1, 128);
    drive_src();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) expect_burst(c, 64, r, 1 + 64 * r);
    rmode = 1;
    wait_drain("t2", 2000);
    for (int c = 0; c < 3; c++) chk("t2_pops", 128'(pops[c]), 128'd128);
    chk("t2_viol", 128'(viol), 128'd0);

    // short final burst then eof
    do_reset();
    src_done = 3'b111;
    push_src(1, 1, 5); drive_src();
    expect_burst(1, 5, 0, 1);
    cyc();
    chk("t3_eof_low", 128'(eof), 128'd0);
    rmode = 1;
    wait_drain("t3", 200);
    repeat (3) cyc();
    chk("t3_eof", 128'(eof), 128'd1);
    chk("t3_pops", 128'(pops[1]), 128'd5);

    // slow reader: FIFO back-pressure
    do_reset();
    push_src(2, 1, 64); drive_src();
    expect_burst(2, 64, 0, 1);
    rmode = 2;
    wait_drain("t4", 1000);
    chk("t4_max_occ", 128'(max_occ), 128'd4);
    chk("t4_pops", 128'(pops[2]), 128'd64);
    chk("t4_viol", 128'(viol), 128'd0);

    // close mid-burst, reopen
    do_reset();
    push_src(0, 1, 128); drive_src();
    expect_burst(0, 64, 0, 1);
    rmode = 1;
    wait_pops("t5_wait", 0, 10);
    open = 1'b0; rmode = 0; rden = 1'b0; sb.delete();
    cyc();
    chk("t5_empty", 128'(empty), 128'd1);
    chk("t5_read", 128'(src_read), 128'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t5_closed_grant", 128'(cur_grant), 128'd3);
      chk("t5_closed_read", 128'(src_read), 128'd0);
    end
    chk("t5_pops_closed", 128'(pops[0]), 128'd10);
    open = 1'b1;
    expect_burst(0, 64, 1, 11);
    rmode = 1;
    wait_drain("t5", 400);
    chk("t5_pops", 128'(pops[0]), 128'd74);

    // reset mid-burst
    do_reset();
    push_src(1, 1, 128); drive_src();
    expect_burst(1, 64, 0, 1);
    rmode = 1;
    wait_pops("t6_wait", 1, 5);
    trn_reset_n = 1'b0; rmode = 0; rden = 1'b0; sb.delete();
    q1.delete(); push_src(0, 1, 128); push_src(1, 1, 128); drive_src();
    cyc();
    chk("t6_read", 128'(src_read), 128'd0);
    chk("t6_empty", 128'(empty), 128'd1);
    chk("t6_eof", 128'(eof), 128'd0);
    chk("t6_grant", 128'(cur_grant), 128'd3);
    chk("t6_data", data, 128'd0);
    q1.delete(); drive_src();
    trn_reset_n = 1'b1;
    begin
      int n = 0;
      while (cur_grant == 2'd3 && n < 10) begin cyc(); n++; end
    end
    chk("t6_first_grant", 128'(cur_grant), 128'd0);
    expect_burst(0, 64, 0, 1);
    rmode = 1;
    wait_drain("t6", 400);
    chk("t6_viol", 128'(viol), 128'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
